// File: rtl/phy_rx_defs_pkg.sv
// Shared definitions for the two-lane PHY receive path: FSM state encodings,
// the default comma symbol and the byte-pair classifier.
package phy_rx_defs;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_LOOP0  = 2'd1,
        ST_LOOP1  = 2'd2,
        ST_ACTIVE = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        PAIR_IDLE = 2'd0,
        PAIR_DATA = 2'd1,
        PAIR_SKEW = 2'd2
    } pair_cls_e;

    localparam logic [7:0] COMMA_DEF = 8'hBC;

    // A pair with a comma on only one lane means the lanes have slipped apart.
    function automatic pair_cls_e classify_pair(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] comma);
        if ((b0 == comma) && (b1 == comma))
            return PAIR_IDLE;
        else if ((b0 != comma) && (b1 != comma))
            return PAIR_DATA;
        else
            return PAIR_SKEW;
    endfunction

endpackage

// File: rtl/phy_rx_word_pack.sv
// Un-stripes two consecutive data byte pairs into one 32-bit word and pulses
// out_valid for a single cycle when the word is complete.
module phy_rx_word_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_pair,
    input  logic        flush,
    input  logic [7:0]  lane0_byte,
    input  logic [7:0]  lane1_byte,
    output logic [31:0] out_bus,
    output logic        out_valid
);

    logic [15:0] hi_p0;
    logic        half_p0;
    logic [31:0] bus_p1;
    logic        vld_p1;

    // Stage 0: capture the upper half-word; stage 1: publish the full word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_p0   <= '0;
            half_p0 <= 1'b0;
            bus_p1  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (flush) begin
                half_p0 <= 1'b0;
            end else if (data_pair) begin
                if (!half_p0) begin
                    hi_p0   <= {lane0_byte, lane1_byte};
                    half_p0 <= 1'b1;
                end else begin
                    bus_p1  <= {hi_p0, lane0_byte, lane1_byte};
                    vld_p1  <= 1'b1;
                    half_p0 <= 1'b0;
                end
            end
        end
    end

    assign out_bus   = bus_p1;
    assign out_valid = vld_p1;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Link-synchronisation controller: counts comma pairs to bring the link up,
// feeds data pairs to the word packer and counts lane-alignment errors.
module phy_rx_sync_ctrl
    import phy_rx_defs::*;
#(
    parameter logic [7:0] COMMA    = COMMA_DEF,
    parameter int         SYNC_CNT = 4,
    parameter int         ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_stb,
    input  logic [7:0]       lane0_byte,
    input  logic [7:0]       lane1_byte,
    output logic [31:0]      out_bus,
    output logic             out_valid,
    output logic             active,
    output logic [1:0]       state,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] SYNC_TGT = 4'(SYNC_CNT);

    rx_state_e        state_p0, state_d;
    logic [3:0]       cnt_p0, cnt_d;
    logic [ERR_W-1:0] err_p0;
    logic             err_inc;
    logic             data_pair;
    logic             flush;
    pair_cls_e        cls;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign cls = classify_pair(lane0_byte, lane1_byte, COMMA);

    always_comb begin
        state_d   = state_p0;
        cnt_d     = cnt_p0;
        err_inc   = 1'b0;
        data_pair = 1'b0;
        flush     = 1'b0;
        unique case (state_p0)
            ST_RESET: begin
                state_d = ST_LOOP0;
                cnt_d   = 4'd0;
            end
            ST_LOOP0: begin
                if (byte_stb && (cls == PAIR_IDLE)) begin
                    cnt_d   = 4'd1;
                    state_d = (SYNC_CNT == 1) ? ST_ACTIVE : ST_LOOP1;
                end
            end
            ST_LOOP1: begin
                if (byte_stb) begin
                    if (cls == PAIR_IDLE) begin
                        cnt_d = cnt_p0 + 4'd1;
                        if (cnt_d == SYNC_TGT)
                            state_d = ST_ACTIVE;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_LOOP0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (byte_stb) begin
                    if (cls == PAIR_DATA) begin
                        data_pair = 1'b1;
                    end else if (cls == PAIR_SKEW) begin
                        flush   = 1'b1;
                        err_inc = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = ST_LOOP0;
                    end
                end
            end
        endcase
    end

    // Stage 0: FSM, comma count and error counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0 <= ST_RESET;
            cnt_p0   <= 4'd0;
            err_p0   <= '0;
        end else begin
            state_p0 <= state_d;
            cnt_p0   <= cnt_d;
            if (err_inc)
                err_p0 <= sat_inc(err_p0);
        end
    end

    phy_rx_word_pack u_word_pack (
        .clk        (clk),
        .reset      (reset),
        .data_pair  (data_pair),
        .flush      (flush),
        .lane0_byte (lane0_byte),
        .lane1_byte (lane1_byte),
        .out_bus    (out_bus),
        .out_valid  (out_valid)
    );

    assign state   = state_p0;
    assign active  = (state_p0 == ST_ACTIVE);
    assign err_cnt = err_p0;

endmodule

// File: doc/phy_rx_sync_ctrl.md
Name: phy_rx_sync_ctrl

Overview:
Link-synchronisation and word-assembly controller for the two-lane PHY receive path. Consumes the byte pairs produced by the per-lane deserialisers. Uses a comma-counting state machine to bring the link up. Sequences byte un-striping into 32-bit words for the receive output bus. It flags loss of lane alignment and counts alignment errors.

Parameters:
COMMA, 8'hBC, idle/sync symbol carried on both lanes
SYNC_CNT, 4, consecutive comma pairs required to declare link active (legal range 1..15)
ERR_W, 8, width of saturating alignment-error counter

Ports:
clk  in  1  single system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
byte_stb  in  1  lane0_byte/lane1_byte hold a new byte pair this cycle; may be high every cycle
lane0_byte  in  8  deserialised byte from serial lane 0
lane1_byte  in  8  deserialised byte from serial lane 1
out_bus  out  32  assembled word; holds last value between words
out_valid  out  1  one-cycle pulse, out_bus carries a new word
active  out  1  high while FSM in ACTIVE
state  out  2  FSM state for debug: 0 RESET, 1 LOOP0, 2 LOOP1, 3 ACTIVE
err_cnt  out  ERR_W  saturating count of alignment errors since reset

Behaviour:
- Reset (reset=0, async): state=RESET, out_bus=0, out_valid=0, active=0, err_cnt=0, comma count=0, half-word flag=0.
- Pair classes, evaluated only when byte_stb=1:
  - IDLE: both lanes == COMMA.
  - DATA: neither lane == COMMA.
  - SKEW: exactly one lane == COMMA.
- Cycles with byte_stb=0 change nothing except clearing out_valid.
- RESET: next clk edge goes to LOOP0 unconditionally, independent of byte_stb.
- LOOP0:
  - IDLE loads count=1. Goes to ACTIVE if SYNC_CNT==1, else to LOOP1.
  - DATA/SKEW: stay in LOOP0.
- LOOP1:
  - IDLE increments count. Goes to ACTIVE when the incremented count == SYNC_CNT.
  - DATA/SKEW: count=0, back to LOOP0. No error counted.
- ACTIVE word assembly:
  - First DATA pair: lane0 goes to word[31:24], lane1 to word[23:16]. Sets half flag.
  - Second DATA pair: lane0 goes to [15:8], lane1 to [7:0]. Clears half flag.
  - On the second pair, out_bus is updated and out_valid=1 on the following cycle. Latency is 1 clk after the sampling edge, single-cycle pulse.
  - IDLE pair: skipped. Partial half-word is retained, so one word may span idle gaps.
  - SKEW pair: partial word discarded (half flag=0, no out_valid). err_cnt increments, saturating at all ones. count=0, state goes to LOOP0, active deasserts next cycle.
- active == (state==ACTIVE). Registered, same cycle as state.
- out_bus is never cleared except by reset. It keeps the last valid word through resync.
- Back-to-back words: DATA pairs on every cycle give out_valid on every second cycle.
- reset asserted mid-word: partial data lost, no out_valid, all outputs to reset values asynchronously.
- count width is 4 bits and never exceeds SYNC_CNT.

Decomposition:
- Shared package/header phy_rx_defs: state encodings ST_RESET/ST_LOOP0/ST_LOOP1/ST_ACTIVE, COMMA default 8'hBC.
- One natural sub-module: phy_rx_word_pack. It handles the half-word register, byte placement and the out_valid pulse. It is driven by data_pair/flush strobes from the FSM top.

Test Plan:
- Reset release, 4 IDLE pairs (BC,BC) on consecutive strobes -> state 0→1→2→2→2→3, active=1 on the cycle after the 4th pair, err_cnt=0.
- Active link, pairs (11,22),(33,44) -> out_bus=32'h11223344, out_valid 1 cycle after the 2nd strobe, for one cycle only.
- Active link, pairs (AA,BB),(BC,BC),(CC,DD) -> idle skipped, out_bus=32'hAABBCCDD, exactly one out_valid.
- Sync 3 IDLE then DATA (01,02) -> back to LOOP0, count cleared. A further 4 IDLE pairs are needed to reach ACTIVE.
- Active, pair (55,66) then SKEW (BC,77) -> no out_valid, err_cnt=1, state=LOOP0, active=0. Repeat 300 skews with resync each time -> err_cnt saturates at 8'hFF.
- Assert reset low between 1st and 2nd data pair -> outputs 0 immediately, no out_valid. After release, state=RESET then LOOP0.
